ssd_image_reader: RTL and testbench
===================================

# ssd_image_reader

Avalon-MM read master that scans a byte image held in the 64K x 8 on-chip image RAM and streams it out as an Avalon-ST byte stream with backpressure. Sits between the image memory slave port and the downstream display/processing pipeline, started by a one-cycle command from the Nios control logic. Decouples memory read latency from sink stalls with a small credit-controlled FIFO.

## Interface
- ADDR_W, 16, image RAM word-address width (bytes)
- DATA_W, 8, pixel/byte width
- READ_LATENCY, 1, fixed slave read latency in cycles (on-chip RAM, unregistered q)
- FIFO_DEPTH, 4, output buffer entries (power of two, >= READ_LATENCY+1)

- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command pulse; honoured only in IDLE
- base_addr  in  ADDR_W  first byte address, sampled on start
- length  in  ADDR_W+1  bytes to transfer, 0..65536, sampled on start
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse when last byte accepted by sink
- m_address  out  ADDR_W  read address to image RAM
- m_chipselect  out  1  asserted together with m_read
- m_read  out  1  read request; slave never stalls
- m_clken  out  1  slave clock enable; constant 1 out of reset
- m_readdata  in  DATA_W  read data, valid READ_LATENCY cycles after m_read
- st_data  out  DATA_W  stream byte
- st_valid  out  1  st_data valid
- st_ready  in  1  sink accepts when st_valid & st_ready
- st_sop  out  1  first byte of transfer
- st_eop  out  1  last byte of transfer

## Operation
- FSM: IDLE -> RUN on start with length != 0; IDLE -> DONE on start with length == 0; RUN -> DRAIN when issued == length; DRAIN -> DONE when last byte accepted; DONE -> IDLE unconditionally (done=1 for exactly that cycle).
- start outside IDLE ignored; base_addr/length changes after start ignored.
- RUN issues m_read=m_chipselect=1 on a cycle iff issued < length AND fifo_count + inflight < FIFO_DEPTH; address = base_addr + issued, modulo 2^ADDR_W (wraps 0xFFFF -> 0x0000).
- inflight tracked by a READ_LATENCY-deep valid shift register; returning m_readdata written into FIFO when shift-register output is 1. FIFO never overflows by construction.
- st_valid = FIFO not empty; st_sop on byte index 0, st_eop on byte index length-1 (both on a single-byte transfer).
- m_address holds last value when m_read low; m_write never driven (read-only master).

## Timing
- Reset values: busy 0, done 0, m_read 0, m_chipselect 0, m_address 0, m_clken 1, st_valid 0, st_sop 0, st_eop 0; FSM IDLE; FIFO empty, counters 0.
- First m_read in cycle after start; first st_valid at start + 1 + READ_LATENCY + 1 (FIFO registered write).
- Sustained throughput 1 byte/cycle with st_ready held high.
- Sink stall: at most FIFO_DEPTH bytes buffered; reads resume in cycle after a pop frees credit.
- Simultaneous FIFO push and pop: both occur, count unchanged.
- done asserted the cycle after the eop handshake; busy falls same cycle done rises.
- Reset mid-transfer: all state cleared immediately (async); in-flight read data discarded; no done pulse.

## Structure
- Package ssd_image_pkg: ADDR_W/DATA_W defaults, FSM state enum (IDLE, RUN, DRAIN, DONE).
- Sub-module ssd_image_reader_fifo: synchronous FIFO with count output, async active-high reset, DEPTH and WIDTH parameters.

## Test plan
- base_addr=0x0010, length=4, st_ready=1 -> reads 0x0010..0x0013 on 4 consecutive cycles; bytes out with sop on first, eop on fourth; done pulse one cycle after fourth handshake.
- base_addr=0xFFFE, length=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; data in that order.
- length=16, st_ready low for 10 cycles after start -> exactly FIFO_DEPTH reads issued, then m_read low until st_ready rises; all 16 bytes delivered in order, none lost or duplicated.
- length=0 -> no m_read, no st_valid, done one cycle after start; length=1 -> single byte with sop=eop=1.
- start pulsed again while busy -> ignored; transfer completes unchanged.
- reset asserted mid-transfer of length=100 -> all outputs to reset values within the same cycle; subsequent start with length=2 delivers correct 2 bytes.

Source files
------------

// File: rtl/ssd_image_pkg.sv
// Shared defaults and FSM encoding for the image reader.
// States are plain localparams so older tools can still read the encoding.
package ssd_image_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StRun   = 2'd1;
  localparam state_t StDrain = 2'd2;
  localparam state_t StDone  = 2'd3;

  function automatic logic is_active(input state_t s);
    return (s == StRun) || (s == StDrain);
  endfunction

endpackage

// File: rtl/ssd_image_reader_fifo.sv
// Synchronous FIFO with occupancy count and fall-through read data.
// DEPTH must be a power of two so the pointers wrap naturally.
module ssd_image_reader_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/ssd_image_reader.sv
// Avalon-MM read master that streams a byte range of the image RAM out as
// Avalon-ST, using FIFO credits so sink stalls never drop returning read data.
module ssd_image_reader
  import ssd_image_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_read,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [ADDR_W:0]         length_q, length_d;
  logic [ADDR_W:0]         issued_q, issued_d;
  logic [ADDR_W:0]         popped_q, popped_d;
  logic [ADDR_W-1:0]       last_addr_q, last_addr_d;
  logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;

  logic [CntW-1:0]   fifo_count;
  logic              fifo_empty;
  logic [31:0]       inflight;
  logic              issue, pop, last_pop, is_last_byte;
  logic [ADDR_W-1:0] rd_addr;

  assign rd_addr      = base_q + issued_q[ADDR_W-1:0];
  assign is_last_byte = (popped_q == length_q - 1'b1);
  assign pop          = st_valid & st_ready;
  assign last_pop     = pop & is_last_byte;

  // Credit check: queued bytes plus reads still in flight must fit the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      inflight = inflight + 32'(rd_pipe_q[i]);
    end
    issue = (state_q == StRun) && (issued_q != length_q) &&
            ((32'(fifo_count) + inflight) < FIFO_DEPTH);
  end

  always_comb begin
    rd_pipe_d[0] = issue;
    for (int i = 1; i < int'(READ_LATENCY); i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    length_d    = length_q;
    issued_d    = issued_q;
    popped_d    = popped_q;
    last_addr_d = last_addr_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          base_d   = base_addr;
          length_d = length;
          issued_d = '0;
          popped_d = '0;
          state_d  = (length == '0) ? StDone : StRun;
        end
      end
      StRun:   if (issued_q == length_q) state_d = StDrain;
      StDrain: if (last_pop) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (issue) begin
      issued_d    = issued_q + 1'b1;
      last_addr_d = rd_addr;
    end
    if (pop) popped_d = popped_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      base_q      <= '0;
      length_q    <= '0;
      issued_q    <= '0;
      popped_q    <= '0;
      last_addr_q <= '0;
      rd_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      length_q    <= length_d;
      issued_q    <= issued_d;
      popped_q    <= popped_d;
      last_addr_q <= last_addr_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

  ssd_image_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rd_pipe_q[READ_LATENCY-1]),
    .wdata (m_readdata),
    .pop   (pop),
    .rdata (st_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_read       = issue;
  assign m_chipselect = issue;
  assign m_address    = issue ? rd_addr : last_addr_q;
  assign m_clken      = 1'b1;
  assign st_valid     = ~fifo_empty;
  assign st_sop       = st_valid && (popped_q == '0);
  assign st_eop       = st_valid && is_last_byte;
  assign busy         = is_active(state_q);
  assign done         = (state_q == StDone);

endmodule

// File: tb/tb_ssd_image_reader.sv
// Directed bench for ssd_image_reader: a latency-1 RAM model feeds the DUT and
// every read and stream handshake is logged, then checked per transfer.
module tb_ssd_image_reader;

  logic        clk = 1'b0;
  logic        reset, start, st_ready;
  logic [15:0] base_addr;
  logic [16:0] length;
  logic        busy, done, m_chipselect, m_read, m_clken;
  logic [15:0] m_address;
  logic [7:0]  m_readdata, st_data;
  logic        st_valid, st_sop, st_eop;

  logic [7:0]  mem [0:65535];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  int          rd_cyc[$];
  logic [15:0] rd_addr[$];
  int          hs_cyc[$];
  logic [7:0]  hs_data[$];
  logic        hs_sop[$];
  logic        hs_eop[$];
  int          n_valid;
  int          bus_err = 0;

  ssd_image_reader #(
    .ADDR_W       (16),
    .DATA_W       (8),
    .READ_LATENCY (1),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_read       (m_read),
    .m_clken      (m_clken),
    .m_readdata   (m_readdata),
    .st_data      (st_data),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_sop       (st_sop),
    .st_eop       (st_eop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    m_readdata <= mem[m_address];
  end

  function automatic logic [7:0] pix(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (m_chipselect !== m_read || m_clken !== 1'b1) bus_err++;
      if (m_read) begin
        rd_cyc.push_back(cyc);
        rd_addr.push_back(m_address);
      end
      if (st_valid) n_valid++;
      if (st_valid && st_ready) begin
        hs_cyc.push_back(cyc);
        hs_data.push_back(st_data);
        hs_sop.push_back(st_sop);
        hs_eop.push_back(st_eop);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // stall: st_ready held low for that many cycles after the start cycle.
  task automatic run_xfer(input logic [15:0] b, input int len, input int stall,
                          input bit restart);
    int s;
    int k;
    int done_cyc;
    int early;
    tick;
    rd_cyc.delete();
    rd_addr.delete();
    hs_cyc.delete();
    hs_data.delete();
    hs_sop.delete();
    hs_eop.delete();
    n_valid   = 0;
    start     = 1'b1;
    base_addr = b;
    length    = 17'(len);
    st_ready  = (stall == 0);
    s         = cyc;
    tick;
    start     = 1'b0;
    base_addr = 16'hDEAD;
    length    = 17'd5;
    if (len != 0) check("busy_after_start", busy, 1);
    done_cyc = -1;
    k = 1;
    while (done_cyc < 0 && k < 400) begin
      st_ready = (stall == 0) || (k > stall);
      start    = restart && (k == 3);
      if (start) begin
        base_addr = 16'h1234;
        length    = 17'd7;
      end
      if (done) begin
        done_cyc = cyc;
        check("busy_low_at_done", busy, 0);
      end else begin
        tick;
        k++;
      end
    end
    start    = 1'b0;
    st_ready = 1'b1;
    if (done_cyc < 0) begin
      check("done_timeout", 0, 1);
      return;
    end
    tick;
    check("done_one_cycle", done, 0);
    check("n_reads", rd_addr.size(), len);
    check("n_beats", hs_data.size(), len);
    for (int i = 0; i < len && i < rd_addr.size(); i++)
      check($sformatf("addr[%0d]", i), rd_addr[i], 16'(b + 16'(i)));
    for (int i = 0; i < len && i < hs_data.size(); i++) begin
      check($sformatf("data[%0d]", i), hs_data[i], pix(16'(b + 16'(i))));
      check($sformatf("sop[%0d]", i), hs_sop[i], (i == 0));
      check($sformatf("eop[%0d]", i), hs_eop[i], (i == len - 1));
    end
    if (len == 0) begin
      check("len0_done_lat", done_cyc, s + 1);
      check("len0_no_valid", n_valid, 0);
    end else if (hs_cyc.size() == len && rd_cyc.size() == len) begin
      check("done_after_eop", done_cyc, hs_cyc[len-1] + 1);
      check("first_read_cyc", rd_cyc[0], s + 1);
      if (stall == 0) begin
        check("first_valid_cyc", hs_cyc[0], s + 3);
        check("reads_back_to_back", rd_cyc[len-1], s + len);
        check("beats_back_to_back", hs_cyc[len-1], s + len + 2);
      end else if (len > 4) begin
        early = 0;
        foreach (rd_cyc[i]) if (rd_cyc[i] <= s + stall + 1) early++;
        check("reads_during_stall", early, 4);
        check("resume_after_pop", rd_cyc[4], s + stall + 2);
      end
    end
  endtask

  initial begin
    int stray_done;
    reset     = 1'b1;
    start     = 1'b0;
    st_ready  = 1'b0;
    base_addr = '0;
    length    = '0;
    for (int i = 0; i < 65536; i++) mem[i] = pix(16'(i));
    tick;
    tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_m_read", m_read, 0);
    check("rst_m_cs", m_chipselect, 0);
    check("rst_m_address", m_address, 0);
    check("rst_m_clken", m_clken, 1);
    check("rst_st_valid", st_valid, 0);
    check("rst_sop_eop", {st_sop, st_eop}, 0);
    reset = 1'b0;
    tick;

    run_xfer(16'h0010, 4, 0, 1'b0);
    run_xfer(16'hFFFE, 4, 0, 1'b0);
    run_xfer(16'h0040, 16, 10, 1'b0);
    run_xfer(16'h0100, 0, 0, 1'b0);
    run_xfer(16'h0123, 1, 0, 1'b0);
    run_xfer(16'h0010, 4, 0, 1'b1);
    run_xfer(16'hFFF0, 40, 0, 1'b0);
    check("m_address_holds", m_address, 16'h0017);

    tick;
    start     = 1'b1;
    base_addr = 16'h0200;
    length    = 17'd100;
    st_ready  = 1'b1;
    tick;
    start = 1'b0;
    repeat (20) tick;
    check("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_m_read", m_read, 0);
    check("arst_m_address", m_address, 0);
    check("arst_st_valid", st_valid, 0);
    check("arst_sop_eop", {st_sop, st_eop}, 0);
    check("arst_done", done, 0);
    tick;
    tick;
    reset = 1'b0;
    stray_done = 0;
    repeat (6) begin
      tick;
      if (done || busy || st_valid || m_read) stray_done++;
    end
    check("post_reset_quiet", stray_done, 0);
    run_xfer(16'h0300, 2, 0, 1'b0);
    check("bus_strobes", bus_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
